acc_search_ctrl: RTL and testbench
==================================

Name: acc_search_ctrl

Overview:
- Parametrised Avalon-MM slave front-end for the hash core: message buffer, digest capture, control/status registers and a handshake to an external hash core.
- Adds a nonce-search mode for the miner. The block re-launches the core with an incremented nonce word until the digest meets a target or the nonce range is exhausted.
- Sits between the HPS lightweight bridge and one hash core instance.

Parameters:
- MSG_WORDS, 16, number of 32-bit message words.
- DIGEST_WORDS, 8, number of 32-bit digest words.
- NONCE_IDX, 3, message word index used as the nonce in search mode (must be < MSG_WORDS).
- ADDR_W, 5, word-address width; requires 2^ADDR_W >= MSG_WORDS+DIGEST_WORDS+6.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- chipselect  in  1  Avalon slave select
- write  in  1  write strobe
- read  in  1  read strobe
- address  in  ADDR_W  word address
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  completion interrupt
- core_start  out  1  one-cycle launch pulse to core
- core_abort  out  1  one-cycle abort pulse to core
- core_msg  out  32*MSG_WORDS  message; word i at [32i+31:32i]
- core_digest  in  32*DIGEST_WORDS  core result, same packing
- core_done  in  1  one-cycle pulse, digest valid in that cycle

Behaviour:
- Address map, with B = MSG_WORDS+DIGEST_WORDS:
  - 0..MSG_WORDS-1: MSG, R/W.
  - MSG_WORDS..B-1: DIGEST, RO.
  - B: CTRL, WO, self-clearing. bit0 START, bit1 ABORT, bit2 SEARCH, bit3 CLR_DONE, bit4 IE.
  - B+1: STATUS, RO. bit0 busy, bit1 done, bit2 found, bit3 exhausted, bit4 wr_err (sticky), bit5 IE.
  - B+2: NONCE_END, R/W.
  - B+3: TARGET, R/W.
  - B+4: NONCE, RO; current value of MSG[NONCE_IDX].
  - B+5: RUNS, RO; completed core runs, saturates at 0xFFFFFFFF.
  - Unmapped addresses: read returns 0, write is ignored.
- Reads: readdata updates on the clock edge after chipselect&read, so latency is 1. Otherwise readdata holds its value. Reset value is 0.
- Reset values: every register, buffer and output is 0.
- FSM states: IDLE, LAUNCH, WAIT, EVAL, DONE.
  - IDLE or DONE + START (ABORT=0): clear done/found/exhausted; RUNS <= 0; latch SEARCH bit and IE bit; go to LAUNCH.
  - LAUNCH: core_start=1 for exactly this cycle; go to WAIT.
  - WAIT + core_done: capture core_digest into DIGEST; RUNS++; go to EVAL. core_done in any other state is ignored.
  - EVAL, non-search run: go to DONE.
  - EVAL, search run, DIGEST[0] <= TARGET (unsigned): found=1; go to DONE.
  - EVAL, search run, else if NONCE == NONCE_END: exhausted=1; go to DONE.
  - EVAL, search run, otherwise: MSG[NONCE_IDX] += 1 (mod 2^32, wraps); go to LAUNCH.
  - DONE: done=1; CLR_DONE goes to IDLE and clears done/found/exhausted. DIGEST and RUNS are retained.
- busy=1 in LAUNCH, WAIT and EVAL.
- ABORT in LAUNCH/WAIT/EVAL: core_abort pulses for 1 cycle; go to IDLE; flags cleared; DIGEST retained. ABORT in IDLE or DONE: go to IDLE, no pulse.
- ABORT and START in the same write: ABORT wins.
- START while busy: ignored.
- MSG write while busy: dropped; wr_err=1. wr_err clears only on CLR_DONE or reset.
- NONCE_END/TARGET writes while busy: take effect from the next EVAL.
- Minimum search-loop period: one core latency + 3 cycles.
- Asynchronous reset mid-run: returns to IDLE immediately; core_start and core_abort go low.

Optional Feature:
- Macro: ACC_IRQ_EN.
- Defined: irq = (state==DONE) & IE_latched; irq is level, cleared by CLR_DONE or ABORT; STATUS bit5 reflects the latched IE.
- Undefined: irq is tied 0; IE writes are ignored; STATUS bit5 reads 0.

Test Plan:
- Write MSG[0..15]=0x1..0x10, CTRL=0x1; core model returns digest word i = 0xA0+i after 64 cycles. Expect:
  - one core_start pulse;
  - STATUS=0x2;
  - DIGEST reads 0xA0..0xA7;
  - RUNS=1.
- Search run: NONCE=MSG[3]=0x100, NONCE_END=0x1FF, TARGET=0x0000FFFF, CTRL=0x5; model returns DIGEST[0]=0x0001_0000 until nonce 0x105, then 0x0000_1234. Expect:
  - found=1;
  - NONCE=0x105;
  - RUNS=6;
  - 6 core_start pulses.
- Search run, NONCE=0xFFFFFFFE, NONCE_END=0x1, target never met. Expect:
  - nonce wraps through 0x0;
  - exhausted=1;
  - NONCE=0x1;
  - RUNS=4.
- Mid-WAIT write CTRL=0x3 (START+ABORT). Expect:
  - single core_abort pulse;
  - state IDLE;
  - STATUS=0x0.
  - A later core_done is ignored (RUNS unchanged).
- MSG write while busy. Expect:
  - buffer unchanged;
  - wr_err=1.
  - Then CLR_DONE clears wr_err.
  - A read of address 31 returns 0 one cycle after read.
- With ACC_IRQ_EN, CTRL=0x11. Expect:
  - irq rises on entry to DONE;
  - irq falls the cycle after CTRL=0x8.
  - Without the macro, irq stays 0 throughout.

Source files
------------

// File: rtl/acc_search_ctrl_if.sv
// acc_search_ctrl_if: Avalon-MM slave bus plus hash-core handshake for acc_search_ctrl.
// The slave modport is the controller side; master is the host/core environment.
interface acc_search_ctrl_if #(
    parameter int MSG_WORDS    = 16,
    parameter int DIGEST_WORDS = 8,
    parameter int ADDR_W       = 5
);
    logic                      chipselect;
    logic                      write;
    logic                      read;
    logic [ADDR_W-1:0]         address;
    logic [31:0]               writedata;
    logic [31:0]               readdata;
    logic                      irq;
    logic                      core_start;
    logic                      core_abort;
    logic [32*MSG_WORDS-1:0]   core_msg;
    logic [32*DIGEST_WORDS-1:0] core_digest;
    logic                      core_done;

    modport slave (
        input  chipselect, write, read, address, writedata, core_digest, core_done,
        output readdata, irq, core_start, core_abort, core_msg
    );
    modport master (
        output chipselect, write, read, address, writedata, core_digest, core_done,
        input  readdata, irq, core_start, core_abort, core_msg
    );
endinterface

// File: rtl/acc_search_ctrl.sv
// acc_search_ctrl: Avalon-MM front-end and nonce-search sequencer for one hash core.
// Defining ACC_IRQ_EN enables the latched-IE level interrupt on completion.
module acc_search_ctrl #(
    parameter int MSG_WORDS    = 16,
    parameter int DIGEST_WORDS = 8,
    parameter int NONCE_IDX    = 3,
    parameter int ADDR_W       = 5
) (
    input logic              clk,
    input logic              reset,
    acc_search_ctrl_if.slave bus
);
    localparam int B = MSG_WORDS + DIGEST_WORDS;
    localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(B);
    localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(B + 1);
    localparam logic [ADDR_W-1:0] A_END   = ADDR_W'(B + 2);
    localparam logic [ADDR_W-1:0] A_TGT   = ADDR_W'(B + 3);
    localparam logic [ADDR_W-1:0] A_NONCE = ADDR_W'(B + 4);
    localparam logic [ADDR_W-1:0] A_RUNS  = ADDR_W'(B + 5);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, EVAL, DONE} state_t;
    state_t r_state, w_next;

    logic [31:0] r_msg [MSG_WORDS];
    logic [31:0] r_dig [DIGEST_WORDS];
    logic [31:0] r_nonce_end, r_target, r_runs, r_rdata, w_rdata;
    logic        r_search, r_found, r_exh, r_wr_err, r_abort, w_ie;
    logic        w_wr, w_ctrl, w_start, w_abort, w_clr, w_msg_wr, w_busy;
    logic        w_hit, w_last, w_go, w_inc, w_cap, w_fin;

    assign w_wr     = bus.chipselect & bus.write;
    assign w_ctrl   = w_wr & (bus.address == A_CTRL);
    assign w_abort  = w_ctrl & bus.writedata[1];
    assign w_start  = w_ctrl & bus.writedata[0] & ~bus.writedata[1];
    assign w_clr    = w_ctrl & bus.writedata[3];
    assign w_msg_wr = w_wr & (bus.address < ADDR_W'(MSG_WORDS));
    assign w_busy   = (r_state == LAUNCH) | (r_state == WAIT) | (r_state == EVAL);
    assign w_hit    = r_dig[0] <= r_target;
    assign w_last   = r_msg[NONCE_IDX] == r_nonce_end;
    assign w_go     = (w_next == LAUNCH) & ((r_state == IDLE) | (r_state == DONE));
    assign w_inc    = (r_state == EVAL) & (w_next == LAUNCH);
    assign w_cap    = (r_state == WAIT) & (w_next == EVAL);
    assign w_fin    = (r_state == EVAL) & (w_next == DONE);

    assign bus.readdata   = r_rdata;
    assign bus.core_start = r_state == LAUNCH;
    assign bus.core_abort = r_abort;
    assign bus.irq        = (r_state == DONE) & w_ie;

    for (genvar i = 0; i < MSG_WORDS; i++) begin : g_msg
        assign bus.core_msg[32*i +: 32] = r_msg[i];
    end

`ifdef ACC_IRQ_EN
    logic r_ie;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_ie <= 1'b0;
        else if (w_go) r_ie <= bus.writedata[4];
    assign w_ie = r_ie;
`else
    assign w_ie = 1'b0;
`endif

    // ABORT overrides every transition, including a START in the same write
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_start ? LAUNCH : IDLE;
            LAUNCH:  w_next = WAIT;
            WAIT:    w_next = bus.core_done ? EVAL : WAIT;
            EVAL:    w_next = (!r_search || w_hit || w_last) ? DONE : LAUNCH;
            DONE:    w_next = w_start ? LAUNCH : w_clr ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else r_state <= w_next;

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < MSG_WORDS; i++)
            if (bus.address == ADDR_W'(i)) w_rdata = r_msg[i];
        for (int i = 0; i < DIGEST_WORDS; i++)
            if (bus.address == ADDR_W'(MSG_WORDS + i)) w_rdata = r_dig[i];
        w_rdata = bus.address == A_STAT  ? {26'd0, w_ie, r_wr_err, r_exh, r_found, r_state == DONE, w_busy} :
                  bus.address == A_END   ? r_nonce_end :
                  bus.address == A_TGT   ? r_target :
                  bus.address == A_NONCE ? r_msg[NONCE_IDX] :
                  bus.address == A_RUNS  ? r_runs : w_rdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_WORDS; i++) r_msg[i] <= '0;
            for (int i = 0; i < DIGEST_WORDS; i++) r_dig[i] <= '0;
            r_nonce_end <= '0;
            r_target    <= '0;
            r_runs      <= '0;
            r_rdata     <= '0;
            r_search    <= 1'b0;
            r_found     <= 1'b0;
            r_exh       <= 1'b0;
            r_wr_err    <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            for (int i = 0; i < MSG_WORDS; i++)
                if (w_msg_wr && !w_busy && bus.address == ADDR_W'(i)) r_msg[i] <= bus.writedata;
                else if (w_inc && i == NONCE_IDX) r_msg[i] <= r_msg[i] + 32'd1;
            for (int i = 0; i < DIGEST_WORDS; i++)
                if (w_cap) r_dig[i] <= bus.core_digest[32*i +: 32];
            if (w_wr && bus.address == A_END) r_nonce_end <= bus.writedata;
            if (w_wr && bus.address == A_TGT) r_target <= bus.writedata;
            if (w_go) r_runs <= '0;
            else if (w_cap && r_runs != '1) r_runs <= r_runs + 32'd1;
            if (w_go) r_search <= bus.writedata[2];
            if (w_fin) begin
                r_found <= r_search & w_hit;
                r_exh   <= r_search & ~w_hit & w_last;
            end else if (w_go | w_abort | w_clr) begin
                r_found <= 1'b0;
                r_exh   <= 1'b0;
            end
            if (w_clr) r_wr_err <= 1'b0;
            else if (w_msg_wr & w_busy) r_wr_err <= 1'b1;
            r_abort <= w_abort & w_busy;
            if (bus.chipselect & bus.read) r_rdata <= w_rdata;
        end
    end
endmodule

// File: tb/tb_acc_search_ctrl.sv
// tb_acc_search_ctrl: directed bench for acc_search_ctrl with a fixed-latency hash core model.
// Honours ACC_IRQ_EN to pick the expected interrupt behaviour.
module tb_acc_search_ctrl;
    localparam logic [4:0] A_CTRL  = 5'd24;
    localparam logic [4:0] A_STAT  = 5'd25;
    localparam logic [4:0] A_END   = 5'd26;
    localparam logic [4:0] A_TGT   = 5'd27;
    localparam logic [4:0] A_NONCE = 5'd28;
    localparam logic [4:0] A_RUNS  = 5'd29;
`ifdef ACC_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          nvec = 0, nerr = 0, n_start = 0, n_abort = 0, n_irq = 0;
    int          lat = 64;
    logic        mode = 1'b0;
    logic        saw_zero = 1'b0;
    logic [31:0] hit_n = '0;

    always #5 clk = ~clk;

    acc_search_ctrl_if #(.MSG_WORDS(16), .DIGEST_WORDS(8), .ADDR_W(5)) bus ();
    acc_search_ctrl #(.MSG_WORDS(16), .DIGEST_WORDS(8), .NONCE_IDX(3), .ADDR_W(5)) dut (
        .clk(clk), .reset(rst), .bus(bus)
    );

    always @(negedge clk) begin
        if (bus.core_start) n_start++;
        if (bus.core_abort) n_abort++;
        if (bus.irq) n_irq++;
    end

    // Core model: fixed latency, ignores abort; search mode hits only at nonce hit_n
    initial begin
        logic [31:0] n;
        bus.core_done   = 1'b0;
        bus.core_digest = '0;
        forever begin
            @(negedge clk);
            if (bus.core_start) begin
                n = bus.core_msg[32*3 +: 32];
                if (n == 32'd0) saw_zero = 1'b1;
                repeat (lat - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) bus.core_digest[32*i +: 32] = 32'hA0 + 32'(i);
                if (mode) bus.core_digest[31:0] = (n == hit_n) ? 32'h0000_1234 : 32'h0001_0000;
                bus.core_done = 1'b1;
                @(negedge clk);
                bus.core_done = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        nvec++;
        assert (obs === want) else begin
            nerr++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        d = bus.readdata;
    endtask

    task automatic wait_nb(input string tag);
        logic [31:0] s;
        int k = 0;
        do begin
            rd(A_STAT, s);
            k++;
        end while (s[0] && k < 3000);
        chk({tag, "_busy_timeout"}, {31'd0, s[0]}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int s0, s1;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", bus.readdata, 32'd0);
        chk("rst_core_start", {31'd0, bus.core_start}, 32'd0);
        chk("rst_irq", {31'd0, bus.irq}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rd(A_STAT, d);   chk("rst_status", d, 32'd0);
        rd(5'd0, d);     chk("rst_msg0", d, 32'd0);

        // Plain hash run
        for (int i = 0; i < 16; i++) wr(5'(i), 32'(i + 1));
        s0 = n_start; mode = 1'b0; lat = 64;
        wr(A_CTRL, 32'h1);
        wait_nb("t1");
        rd(A_STAT, d);   chk("t1_status", d, 32'h2);
        for (int i = 0; i < 8; i++) begin
            rd(5'(16 + i), d);
            chk($sformatf("t1_digest%0d", i), d, 32'hA0 + 32'(i));
        end
        rd(A_RUNS, d);   chk("t1_runs", d, 32'd1);
        chk("t1_starts", 32'(n_start - s0), 32'd1);
        chk("t1_core_msg5", bus.core_msg[32*5 +: 32], 32'd6);

        // Search that finds the target at nonce 0x105
        wr(5'd3, 32'h100); wr(A_END, 32'h1FF); wr(A_TGT, 32'h0000_FFFF);
        mode = 1'b1; hit_n = 32'h105; lat = 4; s0 = n_start;
        wr(A_CTRL, 32'h5);
        wait_nb("t2");
        rd(A_STAT, d);   chk("t2_status_found", d, 32'h6);
        rd(A_NONCE, d);  chk("t2_nonce", d, 32'h105);
        rd(A_RUNS, d);   chk("t2_runs", d, 32'd6);
        chk("t2_starts", 32'(n_start - s0), 32'd6);

        // Search that wraps and exhausts
        wr(5'd3, 32'hFFFF_FFFE); wr(A_END, 32'h1);
        hit_n = 32'h1234_5678;
        wr(A_CTRL, 32'h5);
        wait_nb("t3");
        rd(A_STAT, d);   chk("t3_status_exh", d, 32'hA);
        rd(A_NONCE, d);  chk("t3_nonce", d, 32'h1);
        rd(A_RUNS, d);   chk("t3_runs", d, 32'd4);
        chk("t3_wrapped", {31'd0, saw_zero}, 32'd1);
        rd(A_END, d);    chk("t3_nonce_end", d, 32'h1);
        rd(A_TGT, d);    chk("t3_target", d, 32'h0000_FFFF);

        // START+ABORT while waiting on the core
        mode = 1'b0; lat = 64; s1 = n_start;
        wr(A_CTRL, 32'h1);
        repeat (5) @(negedge clk);
        s0 = n_abort;
        wr(A_CTRL, 32'h3);
        @(negedge clk);
        chk("t4_abort_pulses", 32'(n_abort - s0), 32'd1);
        rd(A_STAT, d);   chk("t4_status_idle", d, 32'd0);
        repeat (80) @(negedge clk);
        rd(A_RUNS, d);   chk("t4_runs_unchanged", d, 32'd0);
        rd(A_STAT, d);   chk("t4_status_after_done", d, 32'd0);
        rd(5'd16, d);    chk("t4_digest_retained", d, 32'h0001_0000);
        chk("t4_starts", 32'(n_start - s1), 32'd1);

        // MSG write while busy, wr_err, unmapped/read-hold behaviour
        wr(A_CTRL, 32'h1);
        wr(5'd0, 32'hDEAD);
        rd(5'd0, d);     chk("t5_msg_unchanged", d, 32'h1);
        rd(A_STAT, d);   chk("t5_status_wrerr_busy", d, 32'h11);
        wait_nb("t5");
        rd(A_STAT, d);   chk("t5_status_wrerr_done", d, 32'h12);
        wr(A_CTRL, 32'h8);
        rd(A_STAT, d);   chk("t5_status_cleared", d, 32'd0);
        rd(5'd1, d);     chk("t5_msg1", d, 32'h2);
        @(negedge clk);
        chk("t5_readdata_hold", bus.readdata, 32'h2);
        rd(5'd31, d);    chk("t5_unmapped", d, 32'd0);
        rd(A_CTRL, d);   chk("t5_ctrl_wo", d, 32'd0);

        // Interrupt behaviour
        lat = 8;
        wr(A_CTRL, 32'h11);
        chk("t6_irq_busy", {31'd0, bus.irq}, 32'd0);
        wait_nb("t6");
        chk("t6_irq_done", {31'd0, bus.irq}, {31'd0, IRQ_EXP});
        rd(A_STAT, d);   chk("t6_status_ie", d, 32'h2 | (32'(IRQ_EXP) << 5));
        wr(A_CTRL, 32'h8);
        chk("t6_irq_cleared", {31'd0, bus.irq}, 32'd0);
`ifndef ACC_IRQ_EN
        chk("t6_irq_never", 32'(n_irq), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
